// File: rtl/steer_en_gen.sv
// Steering-enable controller: detects a balanced rider from the registered wheel speeds
// and gates steering, with weight hysteresis and a debounced step-off.
module steer_en_gen #(
    parameter int W              = 12,
    parameter int MIN_RIDER_WT   = 'h200,
    parameter int WT_HYSTERESIS  = 'h040,
    parameter int SETTLE_CYCLES  = 8,
    parameter int OFF_CYCLES     = 3,
    parameter int RIDER_OFF_MODE = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] lft_spd,
    input  logic [W-1:0] rght_spd,
    output logic         en_steer,
    output logic         rider_off,
    output logic [1:0]   steer_state
);

    localparam int AW = W + 2;
    localparam int TW = $clog2(SETTLE_CYCLES + 1);
    localparam int OW = $clog2(OFF_CYCLES + 1);

    localparam logic signed [AW-1:0] HI_TH    = AW'(MIN_RIDER_WT);
    localparam logic signed [AW-1:0] LO_TH    = AW'(MIN_RIDER_WT - WT_HYSTERESIS);
    localparam logic        [TW-1:0] TMR_MAX  = TW'(SETTLE_CYCLES);
    localparam logic        [OW-1:0] OFF_LAST = OW'(OFF_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        WAIT  = 2'b01,
        STEER = 2'b10
    } state_t;

    state_t                 state, state_nxt;
    logic        [W-1:0]    lft_q, rght_q;
    logic signed [AW-1:0]   lft_x, rght_x, sum, diff, diff_abs;
    logic        [TW-1:0]   timer, timer_nxt;
    logic        [OW-1:0]   off_cnt, off_cnt_nxt;
    logic                   tmr_full, rider_off_nxt;
    logic                   sum_gt_min, sum_lt_min, diff_gt_1_4, diff_gt_15_16;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lft_q  <= '0;
            rght_q <= '0;
        end else begin
            lft_q  <= lft_spd;
            rght_q <= rght_spd;
        end
    end

    // Two guard bits make sum and difference of any W-bit speeds exact.
    assign lft_x    = {{2{lft_q[W-1]}}, lft_q};
    assign rght_x   = {{2{rght_q[W-1]}}, rght_q};
    assign sum      = lft_x + rght_x;
    assign diff     = lft_x - rght_x;
    assign diff_abs = diff[AW-1] ? -diff : diff;

    assign sum_gt_min    = sum > HI_TH;
    assign sum_lt_min    = sum < LO_TH;
    assign diff_gt_1_4   = diff_abs > (sum >>> 2);
    assign diff_gt_15_16 = diff_abs > (sum - (sum >>> 4));
    assign tmr_full      = timer == TMR_MAX;

    always_comb begin
        state_nxt   = state;
        timer_nxt   = '0;
        off_cnt_nxt = '0;
        case (state)
            IDLE: begin
                if (sum_gt_min)
                    state_nxt = WAIT;
            end
            WAIT: begin
                if (sum_lt_min)
                    state_nxt = IDLE;
                else if (diff_gt_1_4)
                    state_nxt = WAIT;
                else if (tmr_full)
                    state_nxt = STEER;
                else
                    timer_nxt = timer + 1'b1;
            end
            STEER: begin
                // A weight dip only counts toward step-off while steering continues.
                if (sum_lt_min && off_cnt == OFF_LAST)
                    state_nxt = IDLE;
                else if (diff_gt_15_16)
                    state_nxt = WAIT;
                else if (sum_lt_min)
                    off_cnt_nxt = off_cnt + 1'b1;
            end
            default: state_nxt = IDLE;
        endcase

        if (RIDER_OFF_MODE != 0)
            rider_off_nxt = state_nxt == IDLE;
        else
            rider_off_nxt = (state_nxt == IDLE) && (state != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            timer     <= '0;
            off_cnt   <= '0;
            rider_off <= RIDER_OFF_MODE != 0;
        end else begin
            state     <= state_nxt;
            timer     <= timer_nxt;
            off_cnt   <= off_cnt_nxt;
            rider_off <= rider_off_nxt;
        end
    end

    assign en_steer    = state == STEER;
    assign steer_state = state;

endmodule

// File: doc/steer_en_gen.md
Name: steer_en_gen

Overview:
Parametrised next-generation steering-enable controller for the Segway balance path. It decides from the left and right wheel speeds whether a rider is aboard and balanced, and gates steering.
- Registered inputs, configurable width, thresholds and settle time.
- Hysteresis on rider weight.
- Debounced step-off, so a short weight dip does not drop steering.
- Selectable pulse or level rider_off.
Sits between the speed-sense front end and the steering/PID mixer.

Parameters:
W, 12, width of signed lft_spd/rght_spd
MIN_RIDER_WT, 12'h200, sum must be strictly greater than this to detect a rider
WT_HYSTERESIS, 12'h040, sum_lt_min threshold is MIN_RIDER_WT - WT_HYSTERESIS
SETTLE_CYCLES, 8, timer terminal count in WAIT (>=1)
OFF_CYCLES, 3, consecutive sum_lt_min cycles required to leave STEER (>=1)
RIDER_OFF_MODE, 0, 0 = one-cycle pulse on entering IDLE; 1 = level high while in IDLE

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
lft_spd  input  W  signed left wheel speed
rght_spd  input  W  signed right wheel speed
en_steer  output  1  high while in STEER
rider_off  output  1  rider-absent indication, per RIDER_OFF_MODE
steer_state  output  2  state code: IDLE=00, WAIT=01, STEER=10

Behaviour:
Reset:
- rst high asynchronously forces: state IDLE, input registers 0, timer 0, off counter 0, en_steer 0.
- rider_off resets to 0 in mode 0 and to 1 in mode 1.
- Reset asserted mid-operation in any state takes effect immediately, without waiting for a clock edge.

Input registers:
- lft_spd and rght_spd are registered on every posedge into lft_q and rght_q.
- All flags are combinational from lft_q and rght_q.

Arithmetic (signed, W+2 bits, sign-extended):
- sum = lft_q + rght_q
- diff_abs = |lft_q - rght_q|
- sum_gt_min = sum > MIN_RIDER_WT (strict)
- sum_lt_min = sum < MIN_RIDER_WT - WT_HYSTERESIS (strict)
- diff_gt_1_4 = diff_abs > (sum >>> 2)
- diff_gt_15_16 = diff_abs > (sum - (sum >>> 4))
- Internal signal names sum_gt_min, sum_lt_min, diff_gt_1_4, diff_gt_15_16 are required; the bench probes them hierarchically.

Timer:
- Counter wide enough to hold SETTLE_CYCLES; tmr_full = (timer == SETTLE_CYCLES).
- Cleared on every transition into WAIT and whenever diff_gt_1_4 is high in WAIT.
- Otherwise increments in WAIT and saturates at SETTLE_CYCLES.

Off counter:
- Active in STEER only: increments while sum_lt_min, clears when sum_lt_min is low.
- Cleared outside STEER.

FSM, evaluated every posedge, first matching rule wins:
- IDLE:
  - sum_gt_min -> WAIT, clear timer.
  - else stay.
- WAIT:
  - sum_lt_min -> IDLE.
  - else diff_gt_1_4 -> stay, clear timer.
  - else tmr_full -> STEER.
  - else stay.
- STEER:
  - sum_lt_min and off counter == OFF_CYCLES-1 -> IDLE.
  - else diff_gt_15_16 -> WAIT, clear timer.
  - else stay.
  - While sum_lt_min is high but not yet debounced, diff_gt_15_16 still applies.

Outputs:
- en_steer = (state == STEER), decoded from the state register.
- rider_off mode 0: registered one-cycle pulse on the edge where the state enters IDLE from WAIT or STEER.
- rider_off mode 1: high exactly while state == IDLE.
- steer_state reflects the state register.

Latency:
- An input applied before edge E0 is sampled at E0 and can change the state at E1.
- With balanced, constant inputs from IDLE: WAIT at E1, tmr_full from E(1+SETTLE_CYCLES), STEER at E(2+SETTLE_CYCLES).

Boundaries:
- sum exactly equal to a threshold does not set either weight flag.
- Sums between the two thresholds hold the current state with respect to weight.
- Negative sums are handled with signed compares and produce no false sum_gt_min.
- No overflow is possible at W+2 bits.

Test Plan:
1. Defaults. lft=rght=12'h180 (sum 0x300) held from reset release, sampled at E0 -> steer_state=01 after E1, en_steer=1 after E10 (not before), rider_off=0.
2. In WAIT, lft=12'h200, rght=12'h100 (diff 0x100 > 0xC0) -> timer held at 0, en_steer stays 0. Restore 12'h180/12'h180 -> en_steer rises 9 edges after the restored value is sampled.
3. In STEER, lft=12'h300, rght=12'h000 (diff 0x300 > 0x2D0) -> steer_state=01 and en_steer=0 one edge after sampling. lft=12'h1C0, rght=12'h140 (diff 0x80 < 0x2D0) -> stays STEER.
4. In STEER, sum 0x1B0 (<0x1C0) for 2 samples then 0x300 -> stays STEER. Sum 0x1B0 for 3 samples -> IDLE on the third edge; mode 0 gives a single-cycle rider_off pulse; mode 1 gives rider_off=1 held.
5. Hysteresis. Sum 0x1E0 from WAIT -> stays WAIT. Sum 0x1E0 from IDLE -> stays IDLE. Sum exactly 0x200 -> stays IDLE. Sum 0x201 -> WAIT.
6. Assert rst between clock edges while in STEER -> en_steer=0 and steer_state=00 immediately. Release with sum 0x300 -> a full settle sequence is required before en_steer=1. Also rerun case 1 with W=16, SETTLE_CYCLES=20 -> en_steer after E22.
